// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit for the Execute stage.
// It retires one bit per cycle, so every op takes a fixed 34-edge latency.
module mult_div_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] ResultHi,
  output logic [31:0] ResultLo,
  output logic        DivByZero
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIXUP = 2'd2} state_t;

  state_t      state_r;
  logic [4:0]  cnt_r;
  logic        is_div_r;
  logic        neg_lo_r;
  logic        neg_hi_r;
  logic        dz_r;
  logic [31:0] opb_r;
  logic [31:0] a_raw_r;
  logic [63:0] acc_r;

  logic        sgn_s;
  logic        sa_s;
  logic        sb_s;
  logic [63:0] acc_next_s;
  logic [32:0] sum_s;
  logic [32:0] shift_s;
  logic [32:0] diff_s;
  logic [63:0] prod_s;
  logic [31:0] res_hi_s;
  logic [31:0] res_lo_s;
  logic        res_dz_s;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic signed_op);
    return (signed_op && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  // Operand sign decode; Op[0]=0 selects the signed variants.
  always_comb begin
    sgn_s = ~Op[0];
    sa_s  = sgn_s & A[31];
    sb_s  = sgn_s & B[31];
  end

  // One iteration step and the final sign fixup of the accumulator.
  always_comb begin
    sum_s      = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opb_r} : 33'd0);
    shift_s    = {acc_r[63:32], acc_r[31]};
    diff_s     = shift_s - {1'b0, opb_r};
    acc_next_s = {sum_s, acc_r[31:1]};
    if (is_div_r) begin
      // Restoring divide: a non-negative trial difference sets the quotient bit.
      if (!diff_s[32]) begin
        acc_next_s = {diff_s[31:0], acc_r[30:0], 1'b1};
      end else begin
        acc_next_s = {shift_s[31:0], acc_r[30:0], 1'b0};
      end
    end else begin
      acc_next_s = {sum_s, acc_r[31:1]};
    end

    prod_s   = neg64(acc_r, neg_lo_r);
    res_hi_s = prod_s[63:32];
    res_lo_s = prod_s[31:0];
    res_dz_s = 1'b0;
    if (dz_r) begin
      res_hi_s = a_raw_r;
      res_lo_s = 32'hFFFF_FFFF;
      res_dz_s = 1'b1;
    end else if (is_div_r) begin
      res_hi_s = neg32(acc_r[63:32], neg_hi_r);
      res_lo_s = neg32(acc_r[31:0], neg_lo_r);
    end else begin
      res_hi_s = prod_s[63:32];
      res_lo_s = prod_s[31:0];
    end
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r   <= IDLE;
      cnt_r     <= 5'd0;
      is_div_r  <= 1'b0;
      neg_lo_r  <= 1'b0;
      neg_hi_r  <= 1'b0;
      dz_r      <= 1'b0;
      opb_r     <= 32'd0;
      a_raw_r   <= 32'd0;
      acc_r     <= 64'd0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      ResultHi  <= 32'd0;
      ResultLo  <= 32'd0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (Start && !Flush) begin
            state_r  <= CALC;
            Busy     <= 1'b1;
            cnt_r    <= 5'd0;
            is_div_r <= Op[1];
            acc_r    <= {32'd0, mag32(A, sgn_s)};
            opb_r    <= mag32(B, sgn_s);
            a_raw_r  <= A;
            neg_lo_r <= sa_s ^ sb_s;
            neg_hi_r <= Op[1] ? sa_s : (sa_s ^ sb_s);
            dz_r     <= Op[1] && (B == 32'd0);
          end else begin
            state_r <= IDLE;
            Busy    <= 1'b0;
          end
        end
        CALC: begin
          if (Flush) begin
            state_r <= IDLE;
            Busy    <= 1'b0;
          end else begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + 5'd1;
            if (cnt_r == 5'd31) begin
              state_r <= FIXUP;
            end else begin
              state_r <= CALC;
            end
          end
        end
        FIXUP: begin
          state_r <= IDLE;
          Busy    <= 1'b0;
          if (Flush) begin
            Done <= 1'b0;
          end else begin
            ResultHi  <= res_hi_s;
            ResultLo  <= res_lo_s;
            DivByZero <= res_dz_s;
            Done      <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
